// File: rtl/shift_bar_display.sv
// Shift register fed on a periodic strobe, merged with a thermometer level bar onto one LED vector.
// Optional peak-hold marker on the bar: define SHIFT_BAR_DISPLAY_PEAK_HOLD_EN.
module shift_bar_display #(
  parameter int WIDTH         = 8,
  parameter int STROBE_PERIOD = 4200000,
  parameter int LEVEL_BITS    = 4,
  parameter int HOLD_STROBES  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_in,
  input  logic                  dir,
  input  logic [LEVEL_BITS-1:0] level,
  input  logic                  level_valid,
  output logic                  strobe,
  output logic [WIDTH-1:0]      shift_out,
  output logic [WIDTH-1:0]      bar_out,
  output logic [WIDTH-1:0]      leds
);

  localparam int CNT_W = $clog2(STROBE_PERIOD);
  localparam int N_W   = $clog2(WIDTH + 1);
  localparam int CMP_W = (LEVEL_BITS > 32) ? LEVEL_BITS : 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_W-1:0]   n_in;
  logic [CMP_W-1:0] level_ext;

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    strobe_d = 1'b0;
    if (cnt_q == CNT_W'(STROBE_PERIOD - 1)) begin
      cnt_d    = '0;
      strobe_d = 1'b1;
    end

    shift_d = shift_q;
    if (strobe_q) begin
      if (dir) shift_d = {shift_q[WIDTH-2:0], sample_in};
      else     shift_d = {sample_in, shift_q[WIDTH-1:1]};
    end

    // Saturate in a width wide enough for both operands so large levels never wrap.
    level_ext = CMP_W'(level);
    if (level_ext >= CMP_W'(WIDTH)) n_in = N_W'(WIDTH);
    else                            n_in = N_W'(level_ext);

    n_d = n_q;
    if (level_valid) n_d = n_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      shift_q  <= '0;
      n_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      shift_q  <= shift_d;
      n_q      <= n_d;
    end
  end

`ifdef SHIFT_BAR_DISPLAY_PEAK_HOLD_EN
  localparam int H_W = (HOLD_STROBES < 1) ? 1 : $clog2(HOLD_STROBES + 1);

  logic [N_W-1:0] p_q, p_d;
  logic [H_W-1:0] hold_q, hold_d;

  // A raising capture takes priority over strobe-driven hold/decay.
  always_comb begin
    p_d    = p_q;
    hold_d = hold_q;
    if (level_valid && (n_in > p_q)) begin
      p_d    = n_in;
      hold_d = H_W'(HOLD_STROBES);
    end else if (strobe_q) begin
      if (hold_q != '0)   hold_d = hold_q - 1'b1;
      else if (p_q > n_q) p_d    = p_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q    <= '0;
      hold_q <= '0;
    end else begin
      p_q    <= p_d;
      hold_q <= hold_d;
    end
  end
`endif

  always_comb begin
    bar_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bar_out[i] = (i + int'(n_q)) >= WIDTH;
`ifdef SHIFT_BAR_DISPLAY_PEAK_HOLD_EN
      if ((i + int'(p_q)) == WIDTH) bar_out[i] = 1'b1;
`endif
    end
  end

  assign strobe    = strobe_q;
  assign shift_out = shift_q;
  assign leds      = shift_q | bar_out;

endmodule
